// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the HD44780 LCD write controller.
// Optional feature macro: LCD_CTRL_LONG_EXEC_EN (long wait after clear/home).
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  // Bit positions inside the core's LCD register
  localparam int unsigned LCD_ON_BIT   = 31;
  localparam int unsigned LCD_EN_BIT   = 10;
  localparam int unsigned LCD_RS_BIT   = 9;
  localparam int unsigned LCD_RW_BIT   = 8;
  localparam int unsigned LCD_DATA_MSB = 7;
  localparam int unsigned LCD_DATA_LSB = 0;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_entry_t;

  // Commands that need the long execution time on the panel
  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME     = 8'h02;
  localparam logic [7:0] LCD_CMD_HOME_ALT = 8'h03;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic is_long_cmd(input lcd_entry_t e);
    return !e.rs && ((e.data == LCD_CMD_CLEAR) || (e.data == LCD_CMD_HOME) ||
                     (e.data == LCD_CMD_HOME_ALT));
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO; a push into a full FIFO is still accepted when
// a pop happens in the same cycle.
module lcd_cmd_fifo
  import lcd_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_push,
  input  lcd_entry_t                    i_push_data,
  input  logic                          i_pop,
  output lcd_entry_t                    o_pop_data,
  output logic                          o_push_ok,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  lcd_entry_t      mem_q [FIFO_DEPTH];
  lcd_entry_t      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_pop;

  assign o_full     = (count_q == CW'(FIFO_DEPTH));
  assign o_empty    = (count_q == '0);
  assign do_pop     = i_pop & ~o_empty;
  assign o_push_ok  = i_push & (~o_full | do_pop);
  assign o_pop_data = mem_q[rd_ptr_q];
  assign o_count    = count_q;

  // Next pointers, count and storage; pointers wrap naturally at power-of-two depth
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (o_push_ok) begin
      mem_d[wr_ptr_q] = i_push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(o_push_ok) - CW'(do_pop);
  end

  // Pointer and count registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, no reset needed
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/lcd_ctrl.sv
// LCD write controller: captures EN edges of the core's LCD register into a
// FIFO and replays each write with setup/pulse/hold/exec timing.
// Optional feature macro: LCD_CTRL_LONG_EXEC_EN.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned T_SETUP     = 3,
  parameter int unsigned T_PULSE     = 12,
  parameter int unsigned T_HOLD      = 3,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 80000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic        o_overflow
);

  localparam int unsigned T_MAX = max_u(max_u(max_u(T_SETUP, T_PULSE), max_u(T_HOLD, T_EXEC)),
                                        T_EXEC_LONG);
  localparam int unsigned CW = $clog2(T_MAX) + 1;
  localparam int unsigned QW = $clog2(FIFO_DEPTH) + 1;

  lcd_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] exec_load;
  logic        en_prev_q, en_prev_d;
  logic        on_q, on_d;
  logic        lcd_en_q, lcd_en_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        overflow_q, overflow_d;
  logic        push_req, push_ok, pop;
  logic        fifo_full, fifo_empty;
  logic [QW-1:0] fifo_count;
  lcd_entry_t  push_entry, pop_entry;
  logic        unused_bits;

  assign push_req        = i_io_lcd[LCD_EN_BIT] & ~en_prev_q & ~i_io_lcd[LCD_RW_BIT];
  assign push_entry.rs   = i_io_lcd[LCD_RS_BIT];
  assign push_entry.data = i_io_lcd[LCD_DATA_MSB:LCD_DATA_LSB];
  assign unused_bits     = ^{i_io_lcd[30:11], fifo_full, fifo_count};

  lcd_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (push_req),
    .i_push_data (push_entry),
    .i_pop       (pop),
    .o_pop_data  (pop_entry),
    .o_push_ok   (push_ok),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count)
  );

`ifdef LCD_CTRL_LONG_EXEC_EN
  logic long_q, long_d;
  assign exec_load = long_q ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);

  // Remember whether the in-flight command needs the long execution wait
  always_comb begin
    long_d = long_q;
    if (pop) long_d = is_long_cmd(pop_entry);
  end

  // Long-wait flag register
  always_ff @(posedge i_clk) begin
    if (i_reset) long_q <= 1'b0;
    else         long_q <= long_d;
  end
`else
  assign exec_load = CW'(T_EXEC - 1);
`endif

  // State, counter and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      en_prev_q  <= 1'b0;
      on_q       <= 1'b0;
      lcd_en_q   <= 1'b0;
      rs_q       <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_prev_q  <= en_prev_d;
      on_q       <= on_d;
      lcd_en_q   <= lcd_en_d;
      rs_q       <= rs_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state and down-counter; the counter is reloaded on every state entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_SETUP;
          cnt_d   = CW'(T_SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_PULSE;
          cnt_d   = CW'(T_PULSE - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = CW'(T_HOLD - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_WAIT;
          cnt_d   = exec_load;
        end else cnt_d = cnt_q - 1'b1;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: enable follows the next state so it is glitch-free from a flop
  always_comb begin
    lcd_en_d   = (state_d == ST_PULSE);
    rs_d       = pop ? pop_entry.rs   : rs_q;
    data_d     = pop ? pop_entry.data : data_q;
    en_prev_d  = i_io_lcd[LCD_EN_BIT];
    on_d       = i_io_lcd[LCD_ON_BIT];
    overflow_d = overflow_q | (push_req & ~push_ok);
  end

  assign o_lcd_on   = on_q;
  assign o_lcd_en   = lcd_en_q;
  assign o_lcd_rs   = rs_q;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_data = data_q;
  assign o_busy     = ~fifo_empty | (state_q != ST_IDLE);
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl with small timing values; compares every
// cycle against a transaction-level model (queue plus command time windows).
module tb_lcd_ctrl;

  localparam int P_DEPTH     = 8;
  localparam int P_SETUP     = 2;
  localparam int P_PULSE     = 3;
  localparam int P_HOLD      = 2;
  localparam int P_EXEC      = 5;
  localparam int P_EXEC_LONG = 20;

  logic        clk;
  logic        i_reset;
  logic [31:0] i_io_lcd;
  logic        o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw, o_busy, o_overflow;
  logic [7:0]  o_lcd_data;

  int n_checks = 0;
  int n_pass   = 0;

  lcd_ctrl #(
    .FIFO_DEPTH  (P_DEPTH),
    .T_SETUP     (P_SETUP),
    .T_PULSE     (P_PULSE),
    .T_HOLD      (P_HOLD),
    .T_EXEC      (P_EXEC),
    .T_EXEC_LONG (P_EXEC_LONG)
  ) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_io_lcd   (i_io_lcd),
    .o_lcd_on   (o_lcd_on),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_data (o_lcd_data),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: each popped command owns a window of edges after its pop
  logic [8:0] mq[$];
  int   m_edge, m_pop_edge, m_span, m_free_edge;
  bit   m_has_cmd, m_prev_en, m_ovf, m_on, m_rs;
  logic [7:0] m_data;

  function automatic int span_of(input logic [8:0] e);
    int  ex;
    bit  is_long;
    ex      = P_EXEC;
    is_long = !e[8] && (e[7:0] >= 8'd1) && (e[7:0] <= 8'd3);
`ifdef LCD_CTRL_LONG_EXEC_EN
    if (is_long) ex = P_EXEC_LONG;
`else
    if (is_long) ex = P_EXEC;
`endif
    return P_SETUP + P_PULSE + P_HOLD + ex;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_has_cmd   = 0;
    m_free_edge = m_edge + 1;
    m_prev_en   = 0;
    m_ovf       = 0;
    m_on        = 0;
    m_rs        = 0;
    m_data      = 8'h00;
  endtask

  task automatic model_step(input logic rst, input logic [31:0] io);
    bit popped;
    logic [8:0] e;
    m_edge++;
    if (rst) begin
      model_reset();
      return;
    end
    popped = 0;
    m_on = io[31];
    if (mq.size() > 0 && m_edge >= m_free_edge) begin
      e           = mq.pop_front();
      m_rs        = e[8];
      m_data      = e[7:0];
      m_pop_edge  = m_edge;
      m_span      = span_of(e);
      m_free_edge = m_edge + m_span + 1;
      m_has_cmd   = 1;
      popped      = 1;
    end
    if (io[10] && !m_prev_en && !io[8]) begin
      if (mq.size() < P_DEPTH) mq.push_back({io[9], io[7:0]});
      else m_ovf = 1;
    end
    m_prev_en = io[10];
    if (popped) m_ovf = m_ovf;
  endtask

  function automatic bit m_en();
    int k;
    k = m_edge - m_pop_edge;
    return m_has_cmd && (k >= P_SETUP) && (k < P_SETUP + P_PULSE);
  endfunction

  function automatic bit m_busy();
    return (mq.size() > 0) || (m_has_cmd && (m_edge < m_pop_edge + m_span));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=0x%0h exp=0x%0h", tag, m_edge, got, exp);
  endtask

  task automatic compare_all();
    check("on",   {31'd0, o_lcd_on},   {31'd0, m_on});
    check("en",   {31'd0, o_lcd_en},   {31'd0, m_en()});
    check("rs",   {31'd0, o_lcd_rs},   {31'd0, m_rs});
    check("rw",   {31'd0, o_lcd_rw},   32'd0);
    check("data", {24'd0, o_lcd_data}, {24'd0, m_data});
    check("busy", {31'd0, o_busy},     {31'd0, m_busy()});
    check("ovf",  {31'd0, o_overflow}, {31'd0, m_ovf});
  endtask

  int en_rises;
  logic en_last;

  task automatic tick(input logic rst, input logic [31:0] io);
    i_reset  = rst;
    i_io_lcd = io;
    @(posedge clk);
    model_step(rst, io);
    #1;
    compare_all();
    if (o_lcd_en && !en_last) en_rises++;
    en_last = o_lcd_en;
  endtask

  initial begin
    logic [31:0] io;
    logic        rst;
    int          bound;
    clk      = 0;
    i_reset  = 1;
    i_io_lcd = '0;
    m_edge   = 0;
    m_pop_edge = 0;
    m_span   = 0;
    en_last  = 0;
    en_rises = 0;
    model_reset();

    repeat (3) tick(1'b1, 32'h0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);

    // Single data write 'A'
    tick(1'b0, 32'h0000_0000);
    tick(1'b0, 32'h8000_0641);
    repeat (20) tick(1'b0, 32'h8000_0241);

    // EN held high for 50 cycles gives exactly one pulse
    tick(1'b0, 32'h0000_0000);
    en_rises = 0;
    repeat (50) tick(1'b0, 32'h8000_0655);
    repeat (10) tick(1'b0, 32'h0000_0000);
    check("held_en_pulses", en_rises, 32'd1);

    // RW=1 write is discarded
    tick(1'b0, 32'h0000_0000);
    en_rises = 0;
    repeat (2) tick(1'b0, 32'h0000_0500);
    repeat (15) tick(1'b0, 32'h0000_0000);
    check("rw_pulses", en_rises, 32'd0);

    // Burst of 12 edges into an 8-deep FIFO
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 32'h0000_0600 | i);
      tick(1'b0, 32'h0000_0200 | i);
    end
    repeat (170) tick(1'b0, 32'h0000_0000);
    check("burst_ovf_sticky", {31'd0, o_overflow}, 32'd1);
    check("burst_drained", {31'd0, o_busy}, 32'd0);

    // Reset in the middle of a pulse
    tick(1'b1, 32'h0);
    tick(1'b0, 32'h0);
    tick(1'b0, 32'h0000_0642);
    bound = 0;
    while (!m_en() && bound < 20) begin
      tick(1'b0, 32'h0000_0642);
      bound++;
    end
    if (bound >= 20) check("pulse_timeout", 32'd0, 32'd1);
    tick(1'b1, 32'h0000_0642);
    check("rst_mid_en", {31'd0, o_lcd_en}, 32'd0);
    check("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    en_rises = 0;
    repeat (30) tick(1'b0, 32'h0000_0000);
    check("rst_mid_no_pulse", en_rises, 32'd0);

    // Clear command followed by a data write
    tick(1'b0, 32'h0000_0401);
    tick(1'b0, 32'h0000_0000);
    tick(1'b0, 32'h0000_0641);
    repeat (60) tick(1'b0, 32'h0000_0000);

    // Randomized traffic
    io = '0;
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 5) == 0) begin
        io    = $urandom;
        io[8] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) == 0) io[7:0] = 8'($urandom_range(1, 3));
        if ($urandom_range(0, 2) == 0) io[10] = 1'b0;
      end
      tick(rst, io);
    end
    repeat (40) tick(1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
